// File: rtl/instr_test_seq.sv
// Self-checking instruction test sequencer: issues vector-ROM instruction words to a core,
// reads back CHECK_REG via the debug port, tallies results. Option macro: TSEQ_STOP_ON_FAIL_EN.
module instr_test_seq #(
    parameter int              XLEN            = 32,
    parameter int              NUM_TESTS       = 3,
    parameter int              INSTRS_PER_TEST = 2,
    parameter logic [4:0]      CHECK_REG       = 5'd3,
    parameter logic [XLEN-1:0] NOP_INSTR       = 32'h0000_0013,
    localparam int             AW              = $clog2(NUM_TESTS * (INSTRS_PER_TEST + 1)),
    localparam int             CW              = $clog2(NUM_TESTS + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [AW-1:0]   vec_addr,
    input  logic [XLEN-1:0] vec_data,
    output logic [XLEN-1:0] imem_out,
    output logic [4:0]      ra3,
    input  logic [XLEN-1:0] rd3,
    output logic            busy,
    output logic            done,
    output logic [CW-1:0]   pass_count,
    output logic [CW-1:0]   fail_count,
    output logic [CW-1:0]   first_fail,
    output logic [1:0]      dbg_state
);

    localparam int SW = $clog2(INSTRS_PER_TEST + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CHECK = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   test, test_n;
    logic [SW-1:0]   slot, slot_n;
    logic [CW-1:0]   pass_n, fail_n, ff_n;
    logic [AW-1:0]   test_base;
    logic            check_ok;
    logic            last_test;
    logic            ra3_live;

    assign dbg_state = state;
    assign test_base = AW'(test) * AW'(INSTRS_PER_TEST + 1);
    assign last_test = (test == CW'(NUM_TESTS - 1));
    // The debug read address only goes live once the block has left reset.
    assign ra3       = ra3_live ? CHECK_REG : 5'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            test       <= '0;
            slot       <= '0;
            pass_count <= '0;
            fail_count <= '0;
            first_fail <= '1;
            ra3_live   <= 1'b0;
        end else begin
            state      <= state_n;
            test       <= test_n;
            slot       <= slot_n;
            pass_count <= pass_n;
            fail_count <= fail_n;
            first_fail <= ff_n;
            ra3_live   <= 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        test_n   = test;
        slot_n   = slot;
        pass_n   = pass_count;
        fail_n   = fail_count;
        ff_n     = first_fail;
        busy     = 1'b0;
        done     = 1'b0;
        imem_out = NOP_INSTR;
        vec_addr = '0;
        check_ok = 1'b0;

        case (state)
            S_IDLE, S_DONE: begin
                done = (state == S_DONE);
                if (start) begin
                    state_n = S_ISSUE;
                    test_n  = '0;
                    slot_n  = '0;
                    pass_n  = '0;
                    fail_n  = '0;
                    ff_n    = '1;
                end
            end

            S_ISSUE: begin
                busy     = 1'b1;
                vec_addr = test_base + AW'(slot);
                imem_out = vec_data;
                if (slot == SW'(INSTRS_PER_TEST - 1)) begin
                    slot_n  = '0;
                    state_n = S_CHECK;
                end else begin
                    slot_n = slot + 1'b1;
                end
            end

            S_CHECK: begin
                busy     = 1'b1;
                vec_addr = test_base + AW'(INSTRS_PER_TEST);
                // Case equality so an unknown read-back is never mistaken for a pass.
                check_ok = (rd3 === vec_data);
                if (check_ok) begin
                    pass_n = pass_count + 1'b1;
                end else begin
                    fail_n = fail_count + 1'b1;
                    if (first_fail == '1) begin
                        ff_n = test;
                    end
                end
`ifdef TSEQ_STOP_ON_FAIL_EN
                if (last_test || !check_ok) begin
`else
                if (last_test) begin
`endif
                    state_n = S_DONE;
                end else begin
                    test_n  = test + 1'b1;
                    state_n = S_ISSUE;
                end
            end

            default: state_n = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_instr_test_seq.sv
// Bench for instr_test_seq: table of directed runs, reset/restart sequences and random tables,
// checked against a small RV32 addi/xori core model and a run-level reference model.
module tb_instr_test_seq;

    localparam int NT  = 3;
    localparam int IPT = 2;
    localparam int WPT = IPT + 1;
    localparam int NW  = NT * WPT;
    localparam int AW  = $clog2(NW);
    localparam int CW  = $clog2(NT + 1);
    localparam logic [31:0]   NOP     = 32'h0000_0013;
    localparam logic [CW-1:0] NO_FAIL = '1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          core_clr = 1'b0;
    logic [AW-1:0] vec_addr;
    logic [31:0]   vec_data, imem_out, rd3;
    logic [4:0]    ra3;
    logic          busy, done;
    logic [CW-1:0] pass_count, fail_count, first_fail;
    logic [1:0]    dbg_state;

    logic [31:0] rom [NW];
    logic [31:0] core_regs [32];
    int          cur_x = -1;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0]   exp_q[$];
    logic [AW-1:0] exp_addr_q[$];

    logic [31:0] base_w [NW] = '{32'h0ff00093, 32'h0000c193, 32'h000000ff,
                                 32'h0ff00093, 32'hfff0c193, 32'hffffff00,
                                 32'h0ff00093, 32'h0ff0c193, 32'h00000000};

    typedef struct {
        logic [31:0] w [NW];
        int x_test;
        int mid;
        int ep, ef, eff, elen;
    } vec_t;
    vec_t tbl [7];

    instr_test_seq dut (
        .clk(clk), .rst(rst), .start(start), .vec_addr(vec_addr), .vec_data(vec_data),
        .imem_out(imem_out), .ra3(ra3), .rd3(rd3), .busy(busy), .done(done),
        .pass_count(pass_count), .fail_count(fail_count), .first_fail(first_fail),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- environment: ROM and core model ----------------
    function automatic logic is_op(input logic [31:0] w);
        return (w[6:0] == 7'h13) && (w[14:12] == 3'd0 || w[14:12] == 3'd4);
    endfunction

    function automatic logic [31:0] alu(input logic [31:0] w, input logic [31:0] a);
        logic [31:0] imm;
        imm = {{20{w[31]}}, w[31:20]};
        return (w[14:12] == 3'd0) ? a + imm : a ^ imm;
    endfunction

    always_comb begin
        vec_data = (int'(vec_addr) < NW) ? rom[vec_addr] : 32'hbad0_bad0;
    end

    always_comb begin
        rd3 = core_regs[ra3];
        if (cur_x >= 0 && busy && int'(vec_addr) == cur_x * WPT + IPT)
            rd3 = {16'hxxxx, 16'hdead};
    end

    always @(posedge clk) begin
        if (core_clr) begin
            for (int i = 0; i < 32; i++) core_regs[i] <= '0;
        end else if (is_op(imem_out) && imem_out[11:7] != 5'd0) begin
            core_regs[imem_out[11:7]] <= alu(imem_out, core_regs[imem_out[19:15]]);
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: walk the table test by test from a cleared register file.
    task automatic model_run(input int x_test, output int ep, output int ef, output int eff,
                             output int elen);
        logic [31:0] r [32];
        logic [31:0] w;
        for (int i = 0; i < 32; i++) r[i] = '0;
        exp_q.delete();
        exp_addr_q.delete();
        ep = 0; ef = 0; eff = -1;
        for (int t = 0; t < NT; t++) begin
            for (int s = 0; s < IPT; s++) begin
                w = rom[t * WPT + s];
                exp_q.push_back(w);
                exp_addr_q.push_back(AW'(t * WPT + s));
                if (is_op(w) && w[11:7] != 5'd0) r[w[11:7]] = alu(w, r[w[19:15]]);
            end
            exp_q.push_back(NOP);
            exp_addr_q.push_back(AW'(t * WPT + IPT));
            if (t != x_test && r[3] == rom[t * WPT + IPT]) begin
                ep++;
            end else begin
                ef++;
                if (eff < 0) eff = t;
`ifdef TSEQ_STOP_ON_FAIL_EN
                break;
`endif
            end
        end
        elen = exp_q.size();
    endtask

    // ---------------- driver ----------------
    task automatic do_run(input string name, input int x_test, input int mid_start,
                          input int tp, input int tf, input int tff, input int tlen);
        int ep, ef, eff, elen, n;
        model_run(x_test, ep, ef, eff, elen);
        cur_x = x_test;
        core_clr = 1'b1;
        @(posedge clk); #1 core_clr = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        n = 0;
        forever begin
            @(negedge clk);
            start = 1'b0;
            if (done) break;
            if (n >= 4 * NW) begin
                n_vec++; n_err++;
                $display("FAIL %s timeout: done not seen after %0d cycles", name, n);
                break;
            end
            check({name, " busy"}, 32'(busy), 32'd1);
            check({name, " ra3"}, 32'(ra3), 32'd3);
            if (exp_q.size() > 0) begin
                check({name, " imem_out"}, imem_out, exp_q.pop_front());
                check({name, " vec_addr"}, 32'(vec_addr), 32'(exp_addr_q.pop_front()));
            end else begin
                n_vec++; n_err++;
                $display("FAIL %s extra busy cycle %0d: imem_out %h", name, n, imem_out);
            end
            if (n == mid_start) start = 1'b1;
            n++;
        end
        check({name, " run length"}, 32'(n), 32'(tlen));
        check({name, " pass_count"}, 32'(pass_count), 32'(tp));
        check({name, " fail_count"}, 32'(fail_count), 32'(tf));
        check({name, " first_fail"}, 32'(first_fail), (tff < 0) ? 32'(NO_FAIL) : 32'(tff));
        check({name, " busy at done"}, 32'(busy), 32'd0);
        cur_x = -1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ep, ef, eff, elen, x, mid;
        logic [31:0] r [32];

        for (int i = 0; i < NW; i++) rom[i] = base_w[i];
        for (int i = 0; i < 7; i++) begin
            tbl[i].w = base_w; tbl[i].x_test = -1; tbl[i].mid = -1;
            tbl[i].ep = 3; tbl[i].ef = 0; tbl[i].eff = -1; tbl[i].elen = 9;
        end
        tbl[1].w[5] = 32'hffffffff;
        tbl[2].w[2] = 32'h00000001;
        tbl[3].w[2] = 32'h1; tbl[3].w[5] = 32'h2; tbl[3].w[8] = 32'h3;
        tbl[4].mid = 4;
        tbl[5].x_test = 0;
`ifdef TSEQ_STOP_ON_FAIL_EN
        tbl[1].ep = 1; tbl[1].ef = 1; tbl[1].eff = 1; tbl[1].elen = 6;
        tbl[2].ep = 0; tbl[2].ef = 1; tbl[2].eff = 0; tbl[2].elen = 3;
        tbl[3].ep = 0; tbl[3].ef = 1; tbl[3].eff = 0; tbl[3].elen = 3;
        tbl[5].ep = 0; tbl[5].ef = 1; tbl[5].eff = 0; tbl[5].elen = 3;
`else
        tbl[1].ep = 2; tbl[1].ef = 1; tbl[1].eff = 1;
        tbl[2].ep = 2; tbl[2].ef = 1; tbl[2].eff = 0;
        tbl[3].ep = 0; tbl[3].ef = 3; tbl[3].eff = 0;
        tbl[5].ep = 2; tbl[5].ef = 1; tbl[5].eff = 0;
`endif

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst pass_count", 32'(pass_count), 32'd0);
        check("rst fail_count", 32'(fail_count), 32'd0);
        check("rst first_fail", 32'(first_fail), 32'(NO_FAIL));
        check("rst imem_out", imem_out, NOP);
        check("rst ra3", 32'(ra3), 32'd0);
        check("rst vec_addr", 32'(vec_addr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle ra3", 32'(ra3), 32'd3);
        check("idle busy", 32'(busy), 32'd0);
        check("idle imem_out", imem_out, NOP);

        // Directed table, run back to back so each restart comes from DONE
        for (int i = 0; i < 7; i++) begin
            for (int k = 0; k < NW; k++) rom[k] = tbl[i].w[k];
            do_run($sformatf("tbl%0d", i), tbl[i].x_test, tbl[i].mid,
                   tbl[i].ep, tbl[i].ef, tbl[i].eff, tbl[i].elen);
        end

        // Reset in the middle of a run, after one test has already been counted
        for (int k = 0; k < NW; k++) rom[k] = base_w[k];
        core_clr = 1'b1;
        @(posedge clk); #1 core_clr = 1'b0;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        check("midrst pass_count", 32'(pass_count), 32'd0);
        check("midrst fail_count", 32'(fail_count), 32'd0);
        check("midrst first_fail", 32'(first_fail), 32'(NO_FAIL));
        check("midrst imem_out", imem_out, NOP);
        check("midrst vec_addr", 32'(vec_addr), 32'd0);
        rst = 1'b0;
        do_run("after_rst", -1, -1, 3, 0, -1, 9);

        // Random tables: addi/xori on x1/x3, expected words mostly correct
        for (int it = 0; it < 25; it++) begin
            for (int i = 0; i < 32; i++) r[i] = '0;
            for (int t = 0; t < NT; t++) begin
                for (int s = 0; s < IPT; s++) begin
                    logic [4:0] rd, rs1;
                    logic [2:0] f3;
                    rd  = ($urandom_range(0, 1) == 0) ? 5'd1 : 5'd3;
                    rs1 = 5'($urandom_range(0, 2));
                    rs1 = (rs1 == 5'd2) ? 5'd3 : rs1;
                    f3  = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'd4;
                    rom[t * WPT + s] = {12'($urandom), rs1, f3, rd, 7'h13};
                    r[rd] = alu(rom[t * WPT + s], r[rs1]);
                end
                rom[t * WPT + IPT] = r[3];
                if ($urandom_range(0, 3) == 0)
                    rom[t * WPT + IPT] = r[3] ^ (32'h1 << $urandom_range(0, 31));
            end
            x = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, NT - 1)) : -1;
            if (x >= 0 && rom[x * WPT + IPT][15:0] == 16'hdead)
                rom[x * WPT + IPT] = rom[x * WPT + IPT] ^ 32'h1;
            mid = int'($urandom_range(0, 12));
            model_run(x, ep, ef, eff, elen);
            do_run($sformatf("rnd%0d", it), x, mid, ep, ef, eff, elen);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
